// File: rtl/mem_bus_responder.sv
// Target side of the CPU byte-serial memory bus: local RAM, UART TX FIFO and halt register.
// Optional write protection of the low RAM region is enabled with `define MEM_RESP_WR_PROTECT_EN.
module mem_bus_responder #(
  parameter int          ADDR_BIT    = 17,
  parameter int          FIFO_BIT    = 3,
  parameter logic [31:0] PROTECT_TOP = 32'h1000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic        wr_err
);

  localparam int               DEPTH   = 2 ** FIFO_BIT;
  localparam logic [FIFO_BIT:0] DEPTH_C = (FIFO_BIT+1)'(DEPTH);
  localparam logic [17:0]      IO_TX   = 18'h30000;
  localparam logic [17:0]      IO_HALT = 18'h30004;

  logic [7:0]          r_ram  [2**ADDR_BIT];
  logic [7:0]          r_fifo [DEPTH];
  logic [FIFO_BIT-1:0] r_head;
  logic [FIFO_BIT-1:0] r_tail;
  logic [FIFO_BIT:0]   r_count;
  logic                r_halt;
  logic                r_wr_err;

  logic [ADDR_BIT-1:0] w_idx;
  logic                w_io;
  logic                w_ram_wr;
  logic                w_blocked;
  logic                w_push;
  logic                w_pop;
  logic                w_unused;

  assign w_idx  = mem_a[ADDR_BIT-1:0];
  assign w_io   = (mem_a[17:16] == 2'b11);
  assign w_pop  = tx_valid && tx_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_push = w_io && mem_wr && (mem_a[17:0] == IO_TX) &&
                  ((r_count < DEPTH_C) || w_pop);

`ifdef MEM_RESP_WR_PROTECT_EN
  assign w_blocked = !w_io && mem_wr && (mem_a < PROTECT_TOP);
`else
  assign w_blocked = 1'b0;
`endif
  assign w_ram_wr = !w_io && mem_wr && !w_blocked;
  assign w_unused = ^{mem_a[31:18], PROTECT_TOP};

  // RAM contents survive reset, so this block carries no reset.
  always_ff @(posedge clk_in) begin
    if (w_ram_wr) r_ram[w_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din <= 8'h00;
    end else if (!mem_wr) begin
      mem_din <= w_io ? 8'h00 : r_ram[w_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_fifo[r_tail] <= mem_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + FIFO_BIT'(1);
      if (w_pop)  r_head <= r_head + FIFO_BIT'(1);
      if (w_push && !w_pop)      r_count <= r_count + (FIFO_BIT+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (FIFO_BIT+1)'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_halt   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      if (w_io && mem_wr && (mem_a[17:0] == IO_HALT)) r_halt <= 1'b1;
      if (w_blocked) r_wr_err <= 1'b1;
    end
  end

  assign tx_valid       = (r_count != '0);
  assign tx_data        = r_fifo[r_head];
  // One slot of slack: the initiator sees the flag a cycle late.
  assign io_buffer_full = (r_count >= DEPTH_C - (FIFO_BIT+1)'(1));
  assign halt           = r_halt;
  assign wr_err         = r_wr_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder: RAM streaming, TX FIFO, halt, reset, protect.
module tb_mem_bus_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;
  logic        wr_err;

  int n_asserts = 0;
  int n_fail    = 0;

  mem_bus_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .halt(halt), .wr_err(wr_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus transaction; returns 1 time unit after the capturing edge.
  task automatic step(input logic [31:0] a, input logic w, input logic [7:0] d);
    mem_a = a; mem_wr = w; mem_dout = d;
    @(posedge clk_in);
    #1;
  endtask

  logic [7:0] exp_drain [8];
  logic [7:0] wdat [4];
  logic [7:0] old_val;

  initial begin
    rst_in = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00; tx_ready = 1'b0;
    #1;
    check("rst_mem_din", {24'h0, mem_din}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_full", {31'h0, io_buffer_full}, 32'h0);
    check("rst_halt", {31'h0, halt}, 32'h0);
    check("rst_wr_err", {31'h0, wr_err}, 32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // RAM write then streamed reads
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    for (int i = 0; i < 4; i++) step(32'h100 + i, 1'b1, wdat[i]);
    check("wr_holds_din", {24'h0, mem_din}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(32'h100 + i, 1'b0, 8'h00);
      check($sformatf("rd_0x%0h", 32'h100 + i), {24'h0, mem_din}, {24'h0, wdat[i]});
    end

    // Fill FIFO with consumer stalled
    for (int i = 0; i < 8; i++) begin
      step(32'h30000, 1'b1, 8'hA0 + 8'(i));
      if (i == 5) check("full_after_6", {31'h0, io_buffer_full}, 32'h0);
      if (i == 6) check("full_after_7", {31'h0, io_buffer_full}, 32'h1);
    end
    check("head_after_fill", {24'h0, tx_data}, 32'hA0);
    step(32'h30000, 1'b1, 8'hEE);  // dropped
    check("full_after_drop", {31'h0, io_buffer_full}, 32'h1);
    check("head_after_drop", {24'h0, tx_data}, 32'hA0);

    // Push into full FIFO with simultaneous pop
    tx_ready = 1'b1;
    step(32'h30000, 1'b1, 8'hAA);
    check("pushpop_head", {24'h0, tx_data}, 32'hA1);
    check("pushpop_full", {31'h0, io_buffer_full}, 32'h1);

    // Drain: exactly 8 bytes in order
    for (int i = 0; i < 7; i++) exp_drain[i] = 8'hA1 + 8'(i);
    exp_drain[7] = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid_%0d", i), {31'h0, tx_valid}, 32'h1);
      check($sformatf("drain_data_%0d", i), {24'h0, tx_data}, {24'h0, exp_drain[i]});
      step(32'h0, 1'b0, 8'h00);
    end
    check("drained_valid", {31'h0, tx_valid}, 32'h0);
    check("drained_full", {31'h0, io_buffer_full}, 32'h0);
    step(32'h0, 1'b0, 8'h00);  // pop on empty ignored
    check("empty_pop_valid", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    step(32'h30000, 1'b1, 8'h5A);
    check("after_underflow_valid", {31'h0, tx_valid}, 32'h1);
    check("after_underflow_data", {24'h0, tx_data}, 32'h5A);
    check("after_underflow_full", {31'h0, io_buffer_full}, 32'h0);

    // Halt and IO reads
    step(32'h30008, 1'b1, 8'hFF);
    check("other_io_no_halt", {31'h0, halt}, 32'h0);
    step(32'h30004, 1'b1, 8'h01);
    check("halt_set", {31'h0, halt}, 32'h1);
    step(32'h100, 1'b0, 8'h00);
    check("rd_before_io", {24'h0, mem_din}, 32'h11);
    step(32'h30000, 1'b0, 8'h00);
    check("io_read_zero", {24'h0, mem_din}, 32'h0);
    check("halt_sticky", {31'h0, halt}, 32'h1);

    // Bring FIFO to 7 entries, then async reset mid-cycle
    for (int i = 0; i < 6; i++) step(32'h30000, 1'b1, 8'hC0 + 8'(i));
    check("pre_rst_full", {31'h0, io_buffer_full}, 32'h1);
    step(32'h101, 1'b0, 8'h00);
    #3 rst_in = 1'b1;
    #1;
    check("midrst_valid", {31'h0, tx_valid}, 32'h0);
    check("midrst_full", {31'h0, io_buffer_full}, 32'h0);
    check("midrst_halt", {31'h0, halt}, 32'h0);
    check("midrst_din", {24'h0, mem_din}, 32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    step(32'h100, 1'b0, 8'h00);
    check("ram_survives_rst", {24'h0, mem_din}, 32'h11);

`ifdef MEM_RESP_WR_PROTECT_EN
    step(32'h0800, 1'b0, 8'h00);
    old_val = mem_din;
    step(32'h0800, 1'b1, 8'h55);
    check("prot_wr_err", {31'h0, wr_err}, 32'h1);
    step(32'h0800, 1'b0, 8'h00);
    check("prot_ram_kept", {24'h0, mem_din}, {24'h0, old_val});
    step(32'h2000, 1'b1, 8'h66);
    step(32'h1000, 1'b1, 8'h77);
    step(32'h2000, 1'b0, 8'h00);
    check("unprot_2000", {24'h0, mem_din}, 32'h66);
    step(32'h1000, 1'b0, 8'h00);
    check("unprot_1000", {24'h0, mem_din}, 32'h77);
    check("wr_err_sticky", {31'h0, wr_err}, 32'h1);
`else
    old_val = 8'h00;
    step(32'h0800, 1'b1, 8'h55);
    check("noprot_wr_err", {31'h0, wr_err}, 32'h0);
    step(32'h0800, 1'b0, 8'h00);
    check("noprot_0800", {24'h0, mem_din}, 32'h55);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
